// File: rtl/mem_mmio_responder_if.sv
// CPU-side bus and external port bundle for mem_mmio_responder.
// master drives the CPU strobes and the external input; slave returns read data and the port.
interface mem_mmio_responder_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] out;
  logic [DATA_WIDTH-1:0] in;
  logic [DATA_WIDTH-1:0] port_out;

  modport master (
    output we,
    output addr,
    output data,
    output in,
    input  out,
    input  port_out
  );

  modport slave (
    input  we,
    input  addr,
    input  data,
    input  in,
    output out,
    output port_out
  );
endinterface

// File: rtl/mem_mmio_responder.sv
// Memory-mapped CPU responder: word RAM plus IN/OUT ports, a prescaled timer and a status word.
// Reads are registered from the current address every cycle; RAM survives reset.
module mem_mmio_responder #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIVISOR    = 5_000_000
) (
  input logic                 clk,
  input logic                 rst,
  mem_mmio_responder_if.slave bus_io
);

  localparam int unsigned RamDepth   = (2 ** ADDR_WIDTH) - 4;
  localparam int unsigned PrescWidth = $clog2(DIVISOR);

  localparam logic [ADDR_WIDTH-1:0] AddrIn     = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 4);
  localparam logic [ADDR_WIDTH-1:0] AddrOut    = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 3);
  localparam logic [ADDR_WIDTH-1:0] AddrTimer  = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 2);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 1);
  localparam logic [PrescWidth-1:0] PrescLast  = PrescWidth'(DIVISOR - 1);

  typedef enum logic [2:0] {
    RegRam,
    RegIn,
    RegOut,
    RegTimer,
    RegStatus
  } region_e;

  region_e region;

  logic [DATA_WIDTH-1:0] ram_q [RamDepth];

  logic [DATA_WIDTH-1:0] out_d, out_q;
  logic [DATA_WIDTH-1:0] port_out_d, port_out_q;
  logic [DATA_WIDTH-1:0] sync1_d, sync1_q;
  logic [DATA_WIDTH-1:0] sync2_d, sync2_q;
  logic [DATA_WIDTH-1:0] sync_prev_d, sync_prev_q;
  logic [DATA_WIDTH-1:0] timer_d, timer_q;
  logic [PrescWidth-1:0] presc_d, presc_q;
  logic                  tick_d, tick_q;
  logic                  in_new_d, in_new_q;

  logic                  wr_en;
  logic                  ram_we;
  logic                  port_wr;
  logic                  timer_wr;
  logic                  status_wr;
  logic                  in_rd;
  logic                  in_changed;
  logic                  presc_wrap;
  logic [DATA_WIDTH-1:0] status_word;

  always_comb begin
    region = RegRam;
    unique case (bus_io.addr)
      AddrIn:     region = RegIn;
      AddrOut:    region = RegOut;
      AddrTimer:  region = RegTimer;
      AddrStatus: region = RegStatus;
      default:    region = RegRam;
    endcase
  end

  always_comb begin
    wr_en       = bus_io.we & ~rst;
    ram_we      = wr_en && (region == RegRam);
    port_wr     = wr_en && (region == RegOut);
    timer_wr    = wr_en && (region == RegTimer);
    status_wr   = wr_en && (region == RegStatus);
    in_rd       = !bus_io.we && (region == RegIn);
    // A change is seen once the synchronized value moves away from its previous sample.
    in_changed  = (sync2_q != sync_prev_q);
    presc_wrap  = (presc_q == PrescLast);
    status_word = {{(DATA_WIDTH - 2){1'b0}}, tick_q, in_new_q};
  end

  always_comb begin
    sync1_d     = bus_io.in;
    sync2_d     = sync1_q;
    sync_prev_d = sync2_q;

    presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    timer_d = presc_wrap ? timer_q + 1'b1 : timer_q;
    // A CPU load overrides the increment but the tick from the same wrap is kept.
    if (timer_wr) begin
      timer_d = bus_io.data;
      presc_d = '0;
    end

    tick_d = tick_q;
    if (status_wr && bus_io.data[1]) begin
      tick_d = 1'b0;
    end
    if (presc_wrap) begin
      tick_d = 1'b1;
    end

    in_new_d = in_new_q;
    if (in_rd || (status_wr && bus_io.data[0])) begin
      in_new_d = 1'b0;
    end
    if (in_changed) begin
      in_new_d = 1'b1;
    end

    port_out_d = port_wr ? bus_io.data : port_out_q;

    // Registers return their pre-edge value; RAM is write-first.
    out_d = '0;
    unique case (region)
      RegRam:    out_d = bus_io.we ? bus_io.data : ram_q[bus_io.addr];
      RegIn:     out_d = sync2_q;
      RegOut:    out_d = port_out_q;
      RegTimer:  out_d = timer_q;
      RegStatus: out_d = status_word;
      default:   out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      port_out_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_prev_q <= '0;
      timer_q     <= '0;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      in_new_q    <= 1'b0;
    end else begin
      out_q       <= out_d;
      port_out_q  <= port_out_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_prev_q <= sync_prev_d;
      timer_q     <= timer_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      in_new_q    <= in_new_d;
    end
  end

  // No reset on the array so its contents persist across rst.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[bus_io.addr] <= bus_io.data;
    end
  end

  assign bus_io.out      = out_q;
  assign bus_io.port_out = port_out_q;

endmodule

// File: tb/tb_mem_mmio_responder.sv
// Scoreboard bench for mem_mmio_responder: a behavioural model queues the expected outputs of
// every clock edge and a negedge monitor compares them against the DUT.
module tb_mem_mmio_responder;

  localparam int unsigned AW       = 6;
  localparam int unsigned DW       = 16;
  localparam int unsigned DIV      = 4;
  localparam int          RamDepth = (2 ** AW) - 4;
  localparam int          AIn      = 60;
  localparam int          AOut     = 61;
  localparam int          ATim     = 62;
  localparam int          ASt      = 63;

  typedef struct {
    logic [DW-1:0] out;
    bit            known;
    logic [DW-1:0] port;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_mmio_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_mmio_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DIVISOR   (DIV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb [$];

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model state.
  logic [DW-1:0] m_ram [int];
  logic [DW-1:0] m_port  = '0;
  logic [DW-1:0] m_timer = '0;
  int unsigned   m_presc = 0;
  bit            m_tick  = 0;
  bit            m_new   = 0;
  // Samples of the input port: [0] newest edge, [1] synchronized value, [2] its previous value.
  logic [DW-1:0] m_pipe [3];

  always @(posedge clk) begin : model
    exp_t          e;
    int            a;
    bit            w;
    logic [DW-1:0] d;
    bit            wrap;
    bit            change;
    e.out   = '0;
    e.known = 1;
    if (rst) begin
      m_port  = '0;
      m_timer = '0;
      m_presc = 0;
      m_tick  = 0;
      m_new   = 0;
      for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    end else begin
      a = int'(bus.addr);
      w = bus.we;
      d = bus.data;
      if (a < RamDepth) begin
        if (w) e.out = d;
        else if (m_ram.exists(a)) e.out = m_ram[a];
        else e.known = 0;
      end else if (a == AIn) e.out = m_pipe[1];
      else if (a == AOut) e.out = m_port;
      else if (a == ATim) e.out = m_timer;
      else e.out[1:0] = {m_tick, m_new};

      change  = (m_pipe[1] != m_pipe[2]);
      m_presc = (m_presc + 1) % DIV;
      wrap    = (m_presc == 0);
      if (w && a == ATim) begin
        m_timer = d;
        m_presc = 0;
      end else if (wrap) begin
        m_timer = m_timer + 16'd1;
      end
      if (wrap) m_tick = 1;
      else if (w && a == ASt && d[1]) m_tick = 0;
      if (change) m_new = 1;
      else if ((!w && a == AIn) || (w && a == ASt && d[0])) m_new = 0;
      if (w && a == AOut) m_port = d;
      if (w && a < RamDepth) m_ram[a] = d;
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = bus.in;
    end
    e.port = m_port;
    sb.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1 at %0t", $time);
    end else begin
      e = sb.pop_front();
      if (e.known) check("out", bus.out, e.out);
      check("port_out", bus.port_out, e.port);
    end
  end

  task automatic step(input logic w, input int a, input logic [DW-1:0] d);
    bus.we   = w;
    bus.addr = AW'(a);
    bus.data = d;
    @(negedge clk);
  endtask

  initial begin
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.data = '0;
    bus.in   = '0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < RamDepth; i++) step(1'b1, i, 16'($urandom));

    // RAM write-first and read-back.
    step(1'b1, 5, 16'hBEEF);
    step(1'b0, 5, '0);
    step(1'b0, 6, '0);
    // Output port.
    step(1'b1, AOut, 16'h1234);
    step(1'b0, AOut, '0);
    step(1'b0, ASt, 16'h0003);
    step(1'b1, ASt, 16'h0003);

    // Input change, detection, clear on IN read.
    bus.in = 16'h00A5;
    repeat (4) step(1'b0, ASt, '0);
    step(1'b0, AIn, '0);
    step(1'b0, ASt, '0);
    // New change landing on the clearing edge keeps in_new set.
    bus.in = 16'h005A;
    step(1'b0, ASt, '0);
    step(1'b0, ASt, '0);
    step(1'b0, AIn, '0);
    step(1'b0, ASt, '0);
    // Writes to IN are ignored.
    step(1'b1, AIn, 16'hFFFF);
    step(1'b0, ASt, '0);
    step(1'b0, AIn, '0);

    // Timer from reset, tick clear, wrap of 0xFFFF.
    rst = 1'b1;
    step(1'b0, ATim, '0);
    rst = 1'b0;
    repeat (6) step(1'b0, ATim, '0);
    step(1'b0, ASt, '0);
    step(1'b1, ASt, 16'h0002);
    step(1'b0, ASt, '0);
    step(1'b1, ATim, 16'hFFFF);
    repeat (6) step(1'b0, ATim, '0);

    // Reset mid-prescale keeps RAM.
    rst = 1'b1;
    step(1'b0, 0, '0);
    rst = 1'b0;
    step(1'b0, ATim, '0);
    step(1'b0, ATim, '0);
    rst = 1'b1;
    step(1'b1, 5, 16'h0000);
    rst = 1'b0;
    step(1'b0, 5, '0);
    step(1'b0, AOut, '0);
    repeat (5) step(1'b0, ATim, '0);

    for (int i = 0; i < 3000; i++) begin
      int            a;
      logic          w;
      logic [DW-1:0] d;
      if ($urandom_range(0, 7) == 0) bus.in = 16'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(60, 63)) : int'($urandom_range(0, 59));
      w = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) d = 16'hFFFF;
      rst = ($urandom_range(0, 199) == 0);
      step(w, a, d);
    end
    rst = 1'b0;
    step(1'b0, 0, '0);
    step(1'b0, 0, '0);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
